bit_serial_add_ctrl: RTL and testbench
======================================

// Module: bit_serial_add_ctrl
// PURPOSE
//  Sequencer for the 8-bit bit-serial adder datapath.
//  - Accepts two parallel operands on a start pulse and shifts them out LSB-first through a 1-bit full adder with a carry flip-flop.
//  - Shifts the sum bits into a right-shifting result register (MSB-in), then presents the sum and carry-out with a one-cycle done pulse.
//  - Sits between the parallel operand source and the serial adder cells.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits; the bit counter is $clog2(WIDTH)+1 bits wide
// PORTS
//  clk     in   1      clock; all state updates on posedge
//  rst     in   1      synchronous, active-high reset
//  start   in   1      request; sampled only in IDLE
//  a       in   WIDTH  operand A, captured on the accepted start
//  b       in   WIDTH  operand B, captured on the accepted start
//  busy    out  1      high in SHIFT and DONE
//  done    out  1      one-cycle pulse in DONE
//  sum     out  WIDTH  result; holds until the next accepted start
//  cout    out  1      final carry; holds with sum
// BEHAVIOUR
//  - Reset (rst=1 at posedge):
//    - state=IDLE; busy=0, done=0, sum=0, cout=0.
//    - Operand shift registers, carry FF and bit counter are cleared.
//    - Reset mid-SHIFT aborts the operation; no done pulse follows.
//  - FSM states: IDLE, SHIFT, DONE.
//    - IDLE: start=1 -> capture a and b, carry=CIN (0), cnt=0, clear the result register, go to SHIFT. start=0 -> stay.
//    - SHIFT, each cycle:
//      - s = a_sr[0]^b_sr[0]^carry; carry <= majority(a_sr[0], b_sr[0], carry).
//      - a_sr and b_sr shift right; result <= {s, result[WIDTH-1:1]}; cnt++.
//      - When cnt==WIDTH-1, go to DONE.
//    - DONE: done=1 for exactly one cycle; sum<=result, cout<=carry; go to IDLE.
//  - Latency: start accepted at edge N -> done high in cycle N+WIDTH+1 (cycle N+9 at WIDTH=8).
//    - sum and cout are valid from that cycle onward.
//  - start while busy=1 (SHIFT or DONE) is ignored, never queued; a and b changes while busy have no effect.
//  - Back-to-back: a start in the IDLE cycle right after DONE is accepted. Minimum issue interval is WIDTH+2 cycles.
//  - Arithmetic: modulo 2^WIDTH; the overflow carry goes only to cout.
//  - If rst and start are both high, rst wins.
// CONFIGURATION
//  SERIAL_SUB_EN
//  - Defined:
//    - Adds input port 'sub' (1 bit), sampled with start.
//    - When sub=1: b is captured inverted (~b) and CIN=1, so sum=a-b mod 2^WIDTH.
//    - cout=1 means no borrow (a>=b unsigned).
//  - Undefined: no 'sub' port; CIN=0; add only.
// STRUCTURE
//  - Shared package bsa_pkg:
//    - state enum {IDLE, SHIFT, DONE} (2-bit localparams);
//    - BSA_WIDTH default = 8;
//    - full-adder function fa_sum/fa_carry.
//  - Sub-module: bsa_piso_reg, a parallel-load, right-shift operand register.
//    - Instantiated twice, for A and B.
//  - The result shift, carry FF, counter and FSM stay in this module.
// TESTING
//  - After rst, all outputs are 0. a=8'h0F, b=8'h01, start pulse -> done at +9 cycles; sum=8'h10, cout=0.
//  - a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. a=8'hAA, b=8'h55 -> sum=8'hFF, cout=0.
//  - start held high for 20 cycles with a=8'h03, b=8'h04 -> done every 10 cycles; sum=8'h07 each time.
//  - Start a=8'h10, b=8'h20, then 3 cycles later start with a=8'hFF -> ignored; sum=8'h30.
//  - rst at shift cycle 4 -> outputs 0, no done pulse. Next start a=8'h01, b=8'h01 -> sum=8'h02.
//  - SERIAL_SUB_EN: sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0. a=8'h07, b=8'h05 -> sum=8'h02, cout=1.

Source files
------------

// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state type,
// default operand width and the 1-bit full-adder helpers.
package bsa_pkg;

    // Default operand/sum width in bits
    localparam int BSA_WIDTH = 8;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Sum bit of a 1-bit full adder
    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    // Carry bit of a 1-bit full adder (majority of the three inputs)
    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (x & ci) | (y & ci);
    endfunction

endpackage

// File: rtl/bsa_piso_reg.sv
// Parallel-load, right-shift operand register. Presents the current LSB
// for the serial adder; zeros are shifted in at the MSB.
module bsa_piso_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             lsb
);

    logic [WIDTH-1:0] data;

    // Load has priority over shift; reset clears the register
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= din;
        end else if (shift) begin
            data <= {1'b0, data[WIDTH-1:1]};
        end
    end

    // Serial output to the full adder
    always_comb begin
        lsb = data[0];
    end

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Sequencer for the bit-serial adder datapath. Captures two operands on an
// accepted start, adds them LSB-first through a 1-bit full adder with a
// carry flip-flop, shifts the sum bits MSB-in into a result register and
// presents sum/cout with a one-cycle done pulse.
// Optional feature macro: SERIAL_SUB_EN (adds 'sub' port for a - b).
module bit_serial_add_ctrl
    import bsa_pkg::*;
#(
    parameter int WIDTH = BSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] result;

    logic             accept;
    logic             shift_en;
    logic             a_bit;
    logic             b_bit;
    logic [WIDTH-1:0] b_load;
    logic             cin;

    // Start is only honoured in IDLE; operands shift only in SHIFT
    always_comb begin
        accept   = (state == IDLE) && start;
        shift_en = (state == SHIFT);
    end

    // Operand B conditioning and carry-in: subtract is a + ~b + 1
    always_comb begin
`ifdef SERIAL_SUB_EN
        b_load = sub ? ~b : b;
        cin    = sub;
`else
        b_load = b;
        cin    = 1'b0;
`endif
    end

    bsa_piso_reg #(
        .WIDTH(WIDTH)
    ) u_a_sr (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .shift(shift_en),
        .din  (a),
        .lsb  (a_bit)
    );

    bsa_piso_reg #(
        .WIDTH(WIDTH)
    ) u_b_sr (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .shift(shift_en),
        .din  (b_load),
        .lsb  (b_bit)
    );

    // Sequencer FSM with carry FF, bit counter, result shifter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        carry  <= cin;
                        cnt    <= '0;
                        result <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    carry  <= fa_carry(a_bit, b_bit, carry);
                    result <= {fa_sum(a_bit, b_bit, carry), result[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    sum   <= result;
                    cout  <= carry;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed self-checking bench for bit_serial_add_ctrl (WIDTH=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bit_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
`ifdef SERIAL_SUB_EN
    logic         sub;
`endif
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int passed = 0;
    int total  = 0;

    bit_serial_add_ctrl #(
        .WIDTH(W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
`ifdef SERIAL_SUB_EN
        .sub  (sub),
`endif
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Wait (bounded) for done; returns negedge count at which it was seen, -1 on timeout
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Count done pulses over n cycles
    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
    endtask

    // One full operation from a negedge: start pulse, latency, result, pulse width
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] es, input logic ec);
        int cyc;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(cyc);
        check({tag, "_lat"}, 32'(cyc), 32'd9);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_sum_hold"}, 32'(sum), 32'(es));
    endtask

    initial begin
        int cyc;
        int n;
        int first_done;
        int second_done;
        int done_seen;
        int sum_bad;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef SERIAL_SUB_EN
        sub   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("add_0f_01", 8'h0F, 8'h01, 8'h10, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
        run_op("add_aa_55", 8'hAA, 8'h55, 8'hFF, 1'b0);
        run_op("add_ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);

        // start held high: accepted every 10 cycles
        a = 8'h03;
        b = 8'h04;
        start = 1'b1;
        first_done = -1;
        second_done = -1;
        done_seen = 0;
        sum_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_seen++;
                if (first_done < 0) first_done = i;
                else second_done = i;
                if (sum !== 8'h07) sum_bad++;
            end
            if (i == 19) start = 1'b0;
        end
        check("held_done_count", 32'(done_seen), 32'd2);
        check("held_first", 32'(first_done), 32'd9);
        check("held_interval", 32'(second_done - first_done), 32'd10);
        check("held_sum_bad", 32'(sum_bad), 32'd0);
        @(negedge clk);
        check("held_idle_after", 32'(busy), 32'd0);

        // start while busy is ignored, new a has no effect
        a = 8'h10;
        b = 8'h20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("ign_lat", 32'(cyc), 32'd6);
        check("ign_sum", 32'(sum), 32'h30);
        check("ign_cout", 32'(cout), 32'd0);
        count_done(12, n);
        check("ign_not_queued", 32'(n), 32'd0);
        check("ign_idle", 32'(busy), 32'd0);

        // reset mid-shift aborts the operation
        a = 8'h3C;
        b = 8'h0F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        count_done(12, n);
        check("abort_no_done", 32'(n), 32'd0);
        run_op("after_abort", 8'h01, 8'h01, 8'h02, 1'b0);

        // rst wins over start
        a = 8'h11;
        b = 8'h22;
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rst_wins_busy", 32'(busy), 32'd0);
        count_done(12, n);
        check("rst_wins_no_done", 32'(n), 32'd0);

`ifdef SERIAL_SUB_EN
        sub = 1'b1;
        run_op("sub_05_07", 8'h05, 8'h07, 8'hFE, 1'b0);
        run_op("sub_07_05", 8'h07, 8'h05, 8'h02, 1'b1);
        run_op("sub_09_09", 8'h09, 8'h09, 8'h00, 1'b1);
        sub = 1'b0;
        run_op("add_after_sub", 8'h07, 8'h05, 8'h0C, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1, "timeout");
    end

endmodule
